sw_scoring_engine: RTL and testbench

Next-generation Smith-Waterman scoring engine with affine gap penalties. It wraps a LENGTH-element systolic array of affine-gap cells, plus a controller FSM. The controller handles query loading with a programmable query length, a valid/ready target stream with end-of-sequence marking, pipeline drain, and a sequential max-reduction across cells. It returns the best local score with its end coordinates over a valid/ready result port, replacing the externally driven output-select mux of the previous scoring module.

---
 rtl/sw_scoring_engine.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sw_scoring_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_scoring_engine.sv
// sw_scoring_engine: Smith-Waterman local alignment scorer with affine gaps.
// A LENGTH-cell linear systolic array (one query base per cell) is fed target
// bases through a valid/ready port. A controller FSM loads the query, streams
// the target, drains the array, then scans the per-cell maxima one cell per
// cycle. The best score and its end coordinates come out on a valid/ready port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_q_load, i_q_len,       query load request, length (1..LENGTH) and bases
//   i_query                  (base j at [2j+1:2j], A=10 G=11 T=00 C=01)
//   i_match, i_mismatch,     substitution bonus/penalty
//   i_gap_open, i_gap_extend affine gap penalties
//   o_cfg_err                one-cycle pulse on a rejected load
//   i_t_valid/o_t_ready,     target base stream, i_t_last marks the final base
//   i_t_base, i_t_last
//   o_res_valid/i_res_ready  result handshake
//   o_res_score, o_res_t_end, o_res_q_end, o_res_ovf   result fields
//   o_busy                   high outside IDLE

// sw_cell: one query base. Consumes token (H(i,j-1), E(i,j-1), target base, i)
// from its left neighbour and forwards (H(i,j), E(i,j), base, i) one cycle
// later. Keeps its own best H and the first target index reaching it.
module sw_cell #(
    parameter int SW = 12,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic [1:0]    i_qbase,
    input  logic [SW-1:0] i_match,
    input  logic [SW-1:0] i_mismatch,
    input  logic [SW-1:0] i_gap_open,
    input  logic [SW-1:0] i_gap_extend,
    input  logic          i_vld,
    input  logic [SW-1:0] i_h,
    input  logic [SW-1:0] i_e,
    input  logic [1:0]    i_base,
    input  logic [TW-1:0] i_idx,
    output logic          o_vld,
    output logic [SW-1:0] o_h,
    output logic [SW-1:0] o_e,
    output logic [1:0]    o_base,
    output logic [TW-1:0] o_idx,
    output logic [SW-1:0] o_max,
    output logic [TW-1:0] o_max_t
);
    function automatic logic [SW-1:0] f_sub(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [SW-1:0] f_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SW] ? '1 : s[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] f_max(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [SW-1:0] r_f;     // F(i-1,j)
    logic [SW-1:0] r_diag;  // H(i-1,j-1): the previous token's left H
    logic [SW-1:0] w_e, w_f, w_d, w_h;

    // o_h doubles as H(i-1,j) for the vertical gap term.
    assign w_e = f_max(f_sub(i_h, i_gap_open), f_sub(i_e, i_gap_extend));
    assign w_f = f_max(f_sub(o_h, i_gap_open), f_sub(r_f, i_gap_extend));
    assign w_d = (i_base == i_qbase) ? f_add(r_diag, i_match) : f_sub(r_diag, i_mismatch);
    assign w_h = f_max(w_d, f_max(w_e, w_f));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_vld   <= 1'b0;
            o_h     <= '0;
            o_e     <= '0;
            o_base  <= '0;
            o_idx   <= '0;
            r_f     <= '0;
            r_diag  <= '0;
            o_max   <= '0;
            o_max_t <= '0;
        end else begin
            o_vld <= i_vld;
            // Bubbles leave all state untouched.
            if (i_vld) begin
                o_h    <= w_h;
                o_e    <= w_e;
                r_f    <= w_f;
                r_diag <= i_h;
                o_base <= i_base;
                o_idx  <= i_idx;
                if (w_h > o_max) begin
                    o_max   <= w_h;
                    o_max_t <= i_idx;
                end
            end
        end
    end
endmodule

module sw_scoring_engine #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 64,
    parameter int LEN_W       = $clog2(LENGTH + 1),
    parameter int TIDX_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_q_load,
    input  logic [LEN_W-1:0]       i_q_len,
    input  logic [2*LENGTH-1:0]    i_query,
    input  logic [SCORE_WIDTH-1:0] i_match,
    input  logic [SCORE_WIDTH-1:0] i_mismatch,
    input  logic [SCORE_WIDTH-1:0] i_gap_open,
    input  logic [SCORE_WIDTH-1:0] i_gap_extend,
    output logic                   o_cfg_err,
    input  logic                   i_t_valid,
    output logic                   o_t_ready,
    input  logic [1:0]             i_t_base,
    input  logic                   i_t_last,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [SCORE_WIDTH-1:0] o_res_score,
    output logic [TIDX_W-1:0]      o_res_t_end,
    output logic [LEN_W-1:0]       o_res_q_end,
    output logic                   o_res_ovf,
    output logic                   o_busy
);
    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_REDUCE, S_DONE} state_t;

    state_t                 r_state;
    logic [2*LENGTH-1:0]    r_query;
    logic [LEN_W-1:0]       r_qlen, r_cnt;
    logic [SCORE_WIDTH-1:0] r_match, r_mis, r_go, r_ge;
    logic [TIDX_W-1:0]      r_tcnt;
    logic                   r_ovf, r_t_ready, r_res_valid, r_busy, r_cfg_err;
    logic [SCORE_WIDTH-1:0] r_best_s;
    logic [TIDX_W-1:0]      r_best_t;
    logic [LEN_W-1:0]       r_best_q;

    logic w_hs, w_len_ok, w_load_ok, w_better, w_unused_tail;
    logic [TIDX_W-1:0] w_tidx;

    // Token chain: entry j feeds cell j, entry j+1 is cell j's output.
    logic [LENGTH:0]                  w_vld;
    logic [LENGTH:0][SCORE_WIDTH-1:0] w_h, w_e, w_max;
    logic [LENGTH:0][1:0]             w_base;
    logic [LENGTH:0][TIDX_W-1:0]      w_idx, w_max_t;

    assign w_hs      = i_t_valid & r_t_ready;
    assign w_len_ok  = (i_q_len != '0) && (i_q_len <= LEN_W'(LENGTH));
    assign w_load_ok = (r_state == S_IDLE) && i_q_load && w_len_ok;
    // Index carried by the injected token saturates together with the counter.
    assign w_tidx    = (r_tcnt == '1) ? r_tcnt : r_tcnt + 1'b1;

    assign w_vld[0]        = w_hs;
    assign w_h[0]          = '0;
    assign w_e[0]          = '0;
    assign w_base[0]       = i_t_base;
    assign w_idx[0]        = w_tidx;
    // Extra slot keeps the reduction mux index exactly LEN_W wide.
    assign w_max[LENGTH]   = '0;
    assign w_max_t[LENGTH] = '0;
    assign w_unused_tail   = ^{w_vld[LENGTH], w_h[LENGTH], w_e[LENGTH], w_base[LENGTH], w_idx[LENGTH]};

    for (genvar j = 0; j < LENGTH; j++) begin : g_cell
        sw_cell #(.SW(SCORE_WIDTH), .TW(TIDX_W)) u_cell (
            .clk(clk), .rst(rst), .i_clr(w_load_ok),
            .i_qbase(r_query[2*j +: 2]),
            .i_match(r_match), .i_mismatch(r_mis), .i_gap_open(r_go), .i_gap_extend(r_ge),
            .i_vld(w_vld[j]), .i_h(w_h[j]), .i_e(w_e[j]), .i_base(w_base[j]), .i_idx(w_idx[j]),
            .o_vld(w_vld[j+1]), .o_h(w_h[j+1]), .o_e(w_e[j+1]), .o_base(w_base[j+1]),
            .o_idx(w_idx[j+1]), .o_max(w_max[j]), .o_max_t(w_max_t[j])
        );
    end

    // Cells are scanned in ascending order, so equal (score, t_end) keeps the
    // lower query index; equal score with a smaller t_end still wins.
    assign w_better = (w_max[r_cnt] > r_best_s) ||
                      ((w_max[r_cnt] == r_best_s) && (w_max_t[r_cnt] < r_best_t));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_query     <= '0;
            r_qlen      <= '0;
            r_match     <= '0;
            r_mis       <= '0;
            r_go        <= '0;
            r_ge        <= '0;
            r_tcnt      <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_best_s    <= '0;
            r_best_t    <= '0;
            r_best_q    <= '0;
            r_t_ready   <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: if (i_q_load) begin
                    if (w_len_ok) begin
                        r_query   <= i_query;
                        r_qlen    <= i_q_len;
                        r_match   <= i_match;
                        r_mis     <= i_mismatch;
                        r_go      <= i_gap_open;
                        r_ge      <= i_gap_extend;
                        r_tcnt    <= '0;
                        r_ovf     <= 1'b0;
                        r_best_s  <= '0;
                        r_best_t  <= '0;
                        r_best_q  <= '0;
                        r_t_ready <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_STREAM;
                    end else begin
                        r_cfg_err <= 1'b1;
                    end
                end
                S_STREAM: if (w_hs) begin
                    if (r_tcnt == '1) r_ovf  <= 1'b1;
                    else              r_tcnt <= r_tcnt + 1'b1;
                    if (i_t_last) begin
                        r_t_ready <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_DRAIN;
                    end
                end
                // q_len cycles: the last token clears cell q_len-1 with margin.
                S_DRAIN: begin
                    if (r_cnt == r_qlen - 1'b1) begin
                        r_cnt   <= '0;
                        r_state <= S_REDUCE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REDUCE: begin
                    if (w_better) begin
                        r_best_s <= w_max[r_cnt];
                        r_best_t <= w_max_t[r_cnt];
                        r_best_q <= r_cnt + 1'b1;
                    end
                    if (r_cnt == r_qlen - 1'b1) begin
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: if (i_res_ready) begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cfg_err   = r_cfg_err;
    assign o_t_ready   = r_t_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_score = r_best_s;
    assign o_res_t_end = r_best_t;
    assign o_res_q_end = r_best_q;
    assign o_res_ovf   = r_ovf;
    assign o_busy      = r_busy;
endmodule

// File: tb/tb_sw_scoring_engine.sv
// Bench for sw_scoring_engine. Two instances share stimulus: a (12-bit scores,
// 16-bit target index) and b (6-bit scores, 4-bit target index) so saturation
// and index overflow are exercised alongside the normal configuration.
module tb_sw_scoring_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst, q_load, t_valid, t_last, res_ready;
    logic [6:0]   q_len;
    logic [127:0] query;
    logic [11:0]  match, mismatch, gap_open, gap_extend;
    logic [1:0]   t_base;

    logic        cfg_err_a, t_ready_a, res_valid_a, ovf_a, busy_a;
    logic [11:0] score_a;
    logic [15:0] tend_a;
    logic [6:0]  qend_a;
    logic        cfg_err_b, t_ready_b, res_valid_b, ovf_b, busy_b;
    logic [5:0]  score_b;
    logic [3:0]  tend_b;
    logic [6:0]  qend_b;

    sw_scoring_engine #(.SCORE_WIDTH(12), .LENGTH(64), .TIDX_W(16)) dut_a (
        .clk(clk), .rst(rst), .i_q_load(q_load), .i_q_len(q_len), .i_query(query),
        .i_match(match), .i_mismatch(mismatch), .i_gap_open(gap_open), .i_gap_extend(gap_extend),
        .o_cfg_err(cfg_err_a), .i_t_valid(t_valid), .o_t_ready(t_ready_a), .i_t_base(t_base),
        .i_t_last(t_last), .o_res_valid(res_valid_a), .i_res_ready(res_ready),
        .o_res_score(score_a), .o_res_t_end(tend_a), .o_res_q_end(qend_a),
        .o_res_ovf(ovf_a), .o_busy(busy_a));

    sw_scoring_engine #(.SCORE_WIDTH(6), .LENGTH(64), .TIDX_W(4)) dut_b (
        .clk(clk), .rst(rst), .i_q_load(q_load), .i_q_len(q_len), .i_query(query),
        .i_match(match[5:0]), .i_mismatch(mismatch[5:0]), .i_gap_open(gap_open[5:0]),
        .i_gap_extend(gap_extend[5:0]),
        .o_cfg_err(cfg_err_b), .i_t_valid(t_valid), .o_t_ready(t_ready_b), .i_t_base(t_base),
        .i_t_last(t_last), .o_res_valid(res_valid_b), .i_res_ready(res_ready),
        .o_res_score(score_b), .o_res_t_end(tend_b), .o_res_q_end(qend_b),
        .o_res_ovf(ovf_b), .o_busy(busy_b));

    int nvec = 0, nmis = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    bit [1:0]   tq[$];
    bit [127:0] qg;

    function automatic bit [1:0] enc(input byte c);
        case (c)
            "A": return 2'b10;
            "G": return 2'b11;
            "T": return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    function automatic void set_q(input string s);
        qg = '0;
        for (int i = 0; i < s.len(); i++) qg[2*i +: 2] = enc(s[i]);
    endfunction

    function automatic void set_t(input string s);
        tq.delete();
        for (int i = 0; i < s.len(); i++) tq.push_back(enc(s[i]));
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Full DP matrix over target rows; each query column remembers its best
    // score and the first row reaching it (row number clipped to the index width).
    // The winner is the highest score, then smallest reported t_end, then smallest q_end.
    function automatic void model(input int W, input int TW, input int qlen,
                                  input int ma, input int mi, input int go, input int ge,
                                  output int sc, output int ts, output int qs);
        int mx, tmax, e, d, h;
        int hp[0:64], hc[0:64], f[0:64], cb[0:64], ct[0:64];
        mx = (1 << W) - 1;
        tmax = (1 << TW) - 1;
        for (int j = 0; j <= 64; j++) begin
            hp[j] = 0; hc[j] = 0; f[j] = 0; cb[j] = 0; ct[j] = 0;
        end
        for (int i = 1; i <= tq.size(); i++) begin
            hc[0] = 0;
            e = 0;
            for (int j = 1; j <= qlen; j++) begin
                e = imax(imax(hc[j-1] - go, 0), imax(e - ge, 0));
                f[j] = imax(imax(hp[j] - go, 0), imax(f[j] - ge, 0));
                if (qg[2*(j-1) +: 2] == tq[i-1]) d = (hp[j-1] + ma > mx) ? mx : hp[j-1] + ma;
                else                             d = imax(hp[j-1] - mi, 0);
                h = imax(d, imax(e, f[j]));
                hc[j] = h;
                if (h > cb[j]) begin
                    cb[j] = h;
                    ct[j] = (i > tmax) ? tmax : i;
                end
            end
            hp = hc;
        end
        sc = 0; ts = 0; qs = 0;
        for (int j = 1; j <= qlen; j++)
            if (cb[j] > sc || (cb[j] == sc && ct[j] < ts)) begin
                sc = cb[j]; ts = ct[j]; qs = j;
            end
    endfunction

    // One complete job on both instances; every observed value is checked
    // against the model, and the result fields are returned for table checks.
    task automatic run_job(input int qlen, input int ma, input int mi, input int go, input int ge,
                           input int bub, input int stall,
                           output int sa, output int ta, output int qa,
                           output int sb, output int tb_, output int qb);
        int esa, eta, eqa, esb, etb, eqb, c_last, k, guard, bad_tr, bad_st;
        model(12, 16, qlen, ma, mi, go, ge, esa, eta, eqa);
        model(6, 4, qlen, ma, mi, go, ge, esb, etb, eqb);
        @(negedge clk);
        q_load = 1; q_len = 7'(qlen); query = qg;
        match = 12'(ma); mismatch = 12'(mi); gap_open = 12'(go); gap_extend = 12'(ge);
        @(negedge clk);
        q_load = 0;
        chk("busy_stream", {busy_a, busy_b, t_ready_a, t_ready_b}, 4'hf);
        k = 0; guard = 0; c_last = 0;
        while (k < tq.size() && guard < 4000) begin
            guard++;
            if (bub > 0 && $urandom_range(99) < bub) begin
                t_valid = 0; t_last = 0;
            end else begin
                t_valid = 1; t_base = tq[k]; t_last = (k == tq.size() - 1);
                if (t_ready_a) begin
                    c_last = cyc;
                    k++;
                end
            end
            @(negedge clk);
        end
        t_valid = 0; t_last = 0;
        chk("bases_accepted", k, tq.size());
        guard = 0; bad_tr = 0;
        while (!res_valid_a && guard < 400) begin
            guard++;
            if (t_ready_a || t_ready_b) bad_tr++;
            @(negedge clk);
        end
        chk("latency", cyc, c_last + 2*qlen + 1);
        bad_st = 0;
        for (int s = 0; s < stall; s++) begin
            if (t_ready_a || t_ready_b || !res_valid_a || !res_valid_b ||
                score_a != esa || tend_a != eta || qend_a != eqa ||
                score_b != esb || tend_b != etb || qend_b != eqb) bad_st++;
            @(negedge clk);
        end
        chk("tready_low_drain", bad_tr, 0);
        chk("stall_hold", bad_st, 0);
        chk("valid_b", res_valid_b, 1);
        res_ready = 1;
        sa = score_a; ta = tend_a; qa = qend_a;
        sb = score_b; tb_ = tend_b; qb = qend_b;
        chk("score_a", sa, esa); chk("tend_a", ta, eta); chk("qend_a", qa, eqa);
        chk("score_b", sb, esb); chk("tend_b", tb_, etb); chk("qend_b", qb, eqb);
        chk("ovf_a", ovf_a, 0);
        chk("ovf_b", ovf_b, (tq.size() > 15) ? 1 : 0);
        @(negedge clk);
        res_ready = 0;
        chk("idle_after", {res_valid_a, busy_a, res_valid_b, busy_b}, 0);
    endtask

    typedef struct {
        string q;
        string t;
        int    ma, mi, go, ge;
        int    es, et, eq;
    } vec_t;

    vec_t tbl[3];
    int   sa, ta, qa, sb, tbv, qb;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; q_load = 0; q_len = 0; query = '0;
        match = 0; mismatch = 0; gap_open = 0; gap_extend = 0;
        t_valid = 0; t_base = 0; t_last = 0; res_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_a", {cfg_err_a, t_ready_a, res_valid_a, score_a, tend_a, qend_a, ovf_a, busy_a}, 0);
        chk("reset_b", {cfg_err_b, t_ready_b, res_valid_b, score_b, tend_b, qend_b, ovf_b, busy_b}, 0);
        rst = 0;

        tbl[0] = '{"ACGT",     "ACGT",      2, 1, 2, 1, 8,  4, 4};
        tbl[1] = '{"AAAATTTT", "AAAACTTTT", 2, 1, 2, 1, 14, 9, 8};
        tbl[2] = '{"AAAA",     "TTTT",      2, 1, 2, 1, 0,  0, 0};
        for (int v = 0; v < 3; v++) begin
            set_q(tbl[v].q);
            set_t(tbl[v].t);
            run_job(tbl[v].q.len(), tbl[v].ma, tbl[v].mi, tbl[v].go, tbl[v].ge, 0, 0,
                    sa, ta, qa, sb, tbv, qb);
            chk("tbl_score_a", sa, tbl[v].es); chk("tbl_tend_a", ta, tbl[v].et);
            chk("tbl_qend_a", qa, tbl[v].eq);
            chk("tbl_score_b", sb, tbl[v].es); chk("tbl_tend_b", tbv, tbl[v].et);
            chk("tbl_qend_b", qb, tbl[v].eq);
        end

        // Bubbles on the target stream and a 20-cycle result stall.
        set_q("ACGT"); set_t("ACGT");
        run_job(4, 2, 1, 2, 1, 40, 20, sa, ta, qa, sb, tbv, qb);
        chk("bubble_score_a", sa, 8);
        chk("bubble_score_b", sb, 8);

        // 64 x A query against 40 x A: instance b saturates score and index.
        set_q({64{"A"}}); set_t({40{"A"}});
        run_job(64, 2, 1, 2, 1, 0, 0, sa, ta, qa, sb, tbv, qb);
        chk("sat_score_b", sb, 63);
        chk("sat_tend_b", tbv, 15);
        chk("sat_qend_b", qb, 32);
        chk("wide_score_a", sa, 80);

        // Rejected loads: q_len=0 and q_len beyond LENGTH.
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            q_load = 1; q_len = (n == 0) ? 7'd0 : 7'd65;
            @(negedge clk);
            q_load = 0;
            chk("cfg_err_pulse", {cfg_err_a, cfg_err_b, busy_a, busy_b, t_ready_a}, 5'b11000);
            @(negedge clk);
            chk("cfg_err_clear", {cfg_err_a, cfg_err_b, busy_a, busy_b, t_ready_a}, 0);
        end

        // Reset in the middle of STREAM, then a clean job.
        set_q("ACGT");
        @(negedge clk);
        q_load = 1; q_len = 4; query = qg;
        match = 2; mismatch = 1; gap_open = 2; gap_extend = 1;
        @(negedge clk);
        q_load = 0; t_valid = 1; t_base = 2'b10;
        @(negedge clk);
        t_base = 2'b01;
        @(negedge clk);
        t_valid = 0; rst = 1;
        @(negedge clk);
        chk("midrst_a", {cfg_err_a, t_ready_a, res_valid_a, score_a, tend_a, qend_a, ovf_a, busy_a}, 0);
        chk("midrst_b", {cfg_err_b, t_ready_b, res_valid_b, score_b, tend_b, qend_b, ovf_b, busy_b}, 0);
        rst = 0;
        set_t("ACGT");
        run_job(4, 2, 1, 2, 1, 0, 0, sa, ta, qa, sb, tbv, qb);
        chk("post_rst_score", sa, 8);

        // Randomised jobs against the model.
        for (int r = 0; r < 12; r++) begin
            int ql, tl, go_r;
            ql = $urandom_range(64, 1);
            qg = {$urandom, $urandom, $urandom, $urandom};
            tl = $urandom_range(24, 1);
            tq.delete();
            for (int i = 0; i < tl; i++) tq.push_back(2'($urandom_range(3, 0)));
            go_r = $urandom_range(7, 0);
            run_job(ql, $urandom_range(7, 1), $urandom_range(7, 0), go_r, $urandom_range(go_r, 0),
                    $urandom_range(50, 0), $urandom_range(3, 0), sa, ta, qa, sb, tbv, qb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
